meta_intf_rr_dispatcher: RTL and testbench
==========================================

# meta_intf_rr_dispatcher

Round-robin dispatcher that distributes one metaIntf input stream across `N_INTERFACES` metaIntf outputs. It is the fan-out counterpart of the round-robin arbiter: a single producer, for example a request queue, spreads work over parallel consumers such as per-stream engines. Ordering within each output is preserved, and each item goes to exactly one output.

## Interface
- `N_INTERFACES`, default `N_STRM_AXI`: number of output interfaces; minimum 1.
- `STYPE`, default `logic[63:0]`: type of the `data` field on the input and on all outputs.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `intf_in`  metaIntf.s  STYPE  input stream (valid/ready/data).
- `intf_out[N_INTERFACES]`  metaIntf.m  STYPE  output streams (valid/ready/data).

## Operation
- Pointer width: `N_BITS = max(1, $clog2(N_INTERFACES))`.
- Reset path:
  - `rst_n` passes through the standard one-stage reset resync register.
  - State clears on the rising edge after the resync register samples 0.
- Storage:
  - One input buffer: `in_buf`, `in_valid`.
  - One output register per port: `out_data[i]`, `out_valid[i]`.
  - `intf_out[i].valid = out_valid[i]` and `intf_out[i].data = out_data[i]`.
- Slot free: `free[i] = !out_valid[i] | intf_out[i].ready`. A slot drained this cycle counts as free.
- Target selection (combinational), given `rr_next`:
  - If `free[rr_next]`, the target is `rr_next`.
  - Otherwise, with the feature off (see Configuration), the target is the first free index scanning `rr_next+1, rr_next+2, …` with wrap modulo `N_INTERFACES`.
  - If no slot is free, nothing is dispatched.
- Dispatch occurs when `in_valid` is high and a target exists:
  - `out_data[t] <= in_buf`, `out_valid[t] <= 1`.
  - `rr_next <= (t == N_INTERFACES-1) ? 0 : t+1`. Wrap is explicit; N need not be a power of two.
- Output slots that are not targeted: on `intf_out[i].ready`, `out_valid[i] <= 0`.
- Input ready: `intf_in.ready = !in_valid | dispatch_this_cycle`.
- Input load:
  - On `intf_in.valid & intf_in.ready`: `in_buf <= data`, `in_valid <= 1`.
  - On ready without valid: `in_valid <= 0`.
- Data registers are not reset; only valid bits and `rr_next` are.
- Reset values:
  - All `intf_out[i].valid` = 0.
  - `intf_in.ready` = 1 once reset is released, since `in_valid` = 0.
  - `rr_next` = 0.
- Reset mid-operation: every buffered item is dropped without being emitted, and no partial handshake completes.

## Timing
- Latency: an item accepted on edge T is presented on `intf_out[t].valid` after edge T+1, at minimum.
- Throughput: 1 item per cycle whenever at least one output is free.
- Handshake rules:
  - `intf_out[i].valid` never drops while ready is low.
  - `data` is stable while valid is high and ready is low.
- Simultaneous events:
  - An output draining in the same cycle it is targeted accepts the new item with no bubble.
  - Input accept and dispatch can occur in the same cycle.
- Full condition: all slots valid and not ready, plus `in_valid`. Then `intf_in.ready` = 0 and the pointer holds.
- `N_INTERFACES = 1`: pass-through with 2 register stages; `rr_next` stays 0.
- Fairness: with all outputs always ready, items go to outputs 0,1,…,N-1,0,…

## Configuration
- Macro: `META_INTF_RR_DISPATCH_STRICT_EN`.
- Defined (strict mode):
  - Dispatch only to `rr_next`; no skip.
  - Item k always goes to output k mod N.
  - A stalled output blocks the input.
  - Downstream order reconstruction by strict round-robin merge becomes possible.
- Undefined (default, work-conserving): skip-to-first-free selection as described above.

## Test plan
- N=4, all outputs always ready, input items 0..11 back-to-back.
  - Required: outputs 0/1/2/3 receive {0,4,8}/{1,5,9}/{2,6,10}/{3,7,11}.
  - Required: 1 item/cycle after initial latency.
- N=4, output 1 ready held low, 8 items, default build.
  - Required: output 1 holds item 1 stable.
  - Required: items 2..7 spread over outputs 2,3,0 with no input stall.
- Same stimulus with `META_INTF_RR_DISPATCH_STRICT_EN`.
  - Required: the input stalls at item 5 until output 1 ready rises.
  - Required: afterwards, the k mod 4 mapping holds.
- N=3 (non-power-of-two), 9 items, all ready.
  - Required: pointer wraps 2→0.
  - Required: each output receives exactly 3 items in order.
- All 4 outputs stalled with a full pipeline.
  - Required: `intf_in.ready` = 0.
  - Then releasing output 2 only: exactly one item moves, to output 2.
- Assert `rst_n` = 0 for 2 cycles while 3 outputs hold valid items.
  - Required: all valid bits 0 after reset is applied.
  - Required: the next dispatched item goes to output 0; dropped items never reappear.

Source files
------------

// File: rtl/meta_intf_rr_dispatcher.sv
// -----------------------------------------------------------------------------
// meta_intf_rr_dispatcher
//   Round-robin fan-out of one valid/ready/data stream onto N_INTERFACES
//   output streams. Each item goes to exactly one output, and each output
//   keeps the order in which it was fed. One input buffer feeds one output
//   register per port.
//
// Configuration macro:
//   META_INTF_RR_DISPATCH_STRICT_EN
//     defined   : strict round-robin. Item k always goes to output k mod N,
//                 and a stalled output blocks the input.
//     undefined : work-conserving. If the pointed-at output is busy, the
//                 item goes to the next free output after the pointer.
//
// Parameters:
//   N_INTERFACES  number of output streams (>= 1)
//   STYPE         payload type of input and outputs
//
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset, resynchronised by one flop
//   intf_in_valid   input stream valid
//   intf_in_ready   input stream ready (combinational)
//   intf_in_data    input stream payload
//   intf_out_valid  per-output valid (registered)
//   intf_out_ready  per-output ready
//   intf_out_data   per-output payload (registered)
// -----------------------------------------------------------------------------
`ifndef N_STRM_AXI
`define N_STRM_AXI 4
`endif

module meta_intf_rr_dispatcher #(
    parameter int unsigned N_INTERFACES = `N_STRM_AXI,
    parameter type         STYPE        = logic [63:0]
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    intf_in_valid,
    output logic                    intf_in_ready,
    input  STYPE                    intf_in_data,
    output logic [N_INTERFACES-1:0] intf_out_valid,
    input  logic [N_INTERFACES-1:0] intf_out_ready,
    output STYPE                    intf_out_data [N_INTERFACES]
);

    localparam int unsigned N_BITS = (N_INTERFACES > 1) ? $clog2(N_INTERFACES) : 1;
    localparam logic [N_BITS-1:0] LAST_IDX = N_BITS'(N_INTERFACES - 1);

    // Reset resync stage
    logic rst_sync_q;

    always_ff @(posedge clk) begin
        rst_sync_q <= rst_n;
    end

    logic                    in_valid_q, in_valid_d;
    STYPE                    in_buf_q, in_buf_d;
    logic [N_INTERFACES-1:0] out_valid_q, out_valid_d;
    STYPE                    out_data_q [N_INTERFACES];
    STYPE                    out_data_d [N_INTERFACES];
    logic [N_BITS-1:0]       rr_next_q, rr_next_d;

    logic [N_INTERFACES-1:0] free_c;
    logic                    tgt_found_c;
    logic [N_BITS-1:0]       tgt_idx_c;
    logic                    dispatch_c;

    // A slot draining this cycle can take a new item with no bubble
    assign free_c = ~out_valid_q | intf_out_ready;

    // Target selection starting at the round-robin pointer
`ifdef META_INTF_RR_DISPATCH_STRICT_EN
    always_comb begin
        tgt_found_c = free_c[rr_next_q];
        tgt_idx_c   = rr_next_q;
    end
`else
    always_comb begin
        int unsigned scan_idx;
        tgt_found_c = 1'b0;
        tgt_idx_c   = '0;
        scan_idx    = 0;
        for (int unsigned off = 0; off < N_INTERFACES; off++) begin
            // Explicit wrap so non-power-of-two N scans correctly
            scan_idx = 32'(rr_next_q) + off;
            if (scan_idx >= N_INTERFACES) begin
                scan_idx = scan_idx - N_INTERFACES;
            end
            if (!tgt_found_c && free_c[scan_idx]) begin
                tgt_found_c = 1'b1;
                tgt_idx_c   = N_BITS'(scan_idx);
            end
        end
    end
`endif

    assign dispatch_c = in_valid_q & tgt_found_c;

    // Ready is held low while the reset stage is active so no handshake completes
    assign intf_in_ready = rst_sync_q & (~in_valid_q | dispatch_c);

    // Next-state logic for buffer, output slots and pointer
    always_comb begin
        in_valid_d  = in_valid_q;
        in_buf_d    = in_buf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_next_d   = rr_next_q;

        for (int unsigned i = 0; i < N_INTERFACES; i++) begin
            if (intf_out_ready[i]) begin
                out_valid_d[i] = 1'b0;
            end
        end

        if (dispatch_c) begin
            out_valid_d[tgt_idx_c] = 1'b1;
            out_data_d[tgt_idx_c]  = in_buf_q;
            rr_next_d = (tgt_idx_c == LAST_IDX) ? '0 : tgt_idx_c + N_BITS'(1);
        end

        if (intf_in_ready) begin
            in_valid_d = intf_in_valid;
            if (intf_in_valid) begin
                in_buf_d = intf_in_data;
            end
        end
    end

    // Control state: valid bits and pointer
    always_ff @(posedge clk) begin
        if (!rst_sync_q) begin
            in_valid_q  <= 1'b0;
            out_valid_q <= '0;
            rr_next_q   <= '0;
        end else begin
            in_valid_q  <= in_valid_d;
            out_valid_q <= out_valid_d;
            rr_next_q   <= rr_next_d;
        end
    end

    // Payload registers carry no reset
    always_ff @(posedge clk) begin
        in_buf_q   <= in_buf_d;
        out_data_q <= out_data_d;
    end

    assign intf_out_valid = out_valid_q;
    assign intf_out_data  = out_data_q;

endmodule

// File: tb/tb_meta_intf_rr_dispatcher.sv
// Bench for meta_intf_rr_dispatcher: an N=4 and an N=3 instance, with directed
// stimulus. Expected items are queued per output, and a monitor pops and
// compares them on every output handshake.
module tb_meta_intf_rr_dispatcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v4, r4;
    logic [15:0] i_d4;
    logic [3:0]  ov4, or4;
    logic [15:0] od4 [4];

    logic        v3, r3;
    logic [15:0] i_d3;
    logic [2:0]  ov3, or3;
    logic [15:0] od3 [3];

    meta_intf_rr_dispatcher #(.N_INTERFACES(4), .STYPE(logic [15:0])) dut4 (
        .clk(clk), .rst_n(rst_n),
        .intf_in_valid(v4), .intf_in_ready(r4), .intf_in_data(i_d4),
        .intf_out_valid(ov4), .intf_out_ready(or4), .intf_out_data(od4)
    );

    meta_intf_rr_dispatcher #(.N_INTERFACES(3), .STYPE(logic [15:0])) dut3 (
        .clk(clk), .rst_n(rst_n),
        .intf_in_valid(v3), .intf_in_ready(r3), .intf_in_data(i_d3),
        .intf_out_valid(ov3), .intf_out_ready(or3), .intf_out_data(od3)
    );

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int cyc    = 0;
    int phase  = 0;
    int first_pop = -1;
    int last_pop  = -1;

    logic [15:0] exp4 [4][$];
    logic [15:0] exp3 [3][$];
    logic [15:0] e4, e3;

`ifdef META_INTF_RR_DISPATCH_STRICT_EN
    int t2_map [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int t3_last = 0;
`else
    int t2_map [8] = '{0, 1, 2, 3, 0, 2, 3, 0};
    int t3_last = 2;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output handshake must match the head of its queue
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ov4[i] && or4[i]) begin
                checks++;
                if (exp4[i].size() == 0) begin
                    errors++;
                    $display("FAIL sb4_unexpected out%0d actual=%0h required=none", i, od4[i]);
                end else begin
                    e4 = exp4[i].pop_front();
                    if (od4[i] !== e4) begin
                        errors++;
                        $display("FAIL sb4_data out%0d actual=%0h required=%0h", i, od4[i], e4);
                    end
                end
                if (phase == 1) begin
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (ov3[i] && or3[i]) begin
                checks++;
                if (exp3[i].size() == 0) begin
                    errors++;
                    $display("FAIL sb3_unexpected out%0d actual=%0h required=none", i, od3[i]);
                end else begin
                    e3 = exp3[i].pop_front();
                    if (od3[i] !== e3) begin
                        errors++;
                        $display("FAIL sb3_data out%0d actual=%0h required=%0h", i, od3[i], e3);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one item on instance d (0: N=4, 1: N=3) and hold it until accepted
    task automatic send(input int d, input logic [15:0] v);
        int n;
        n = 0;
        if (d == 0) begin v4 = 1'b1; i_d4 = v; end
        else        begin v3 = 1'b1; i_d3 = v; end
        forever begin
            @(negedge clk);
            if ((d == 0) ? r4 : r3) break;
            stalls++;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout dut%0d item=%0h actual=no_ready required=ready", d, v);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (d == 0) v4 = 1'b0;
        else        v3 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_drained(input string tag);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_left4_out%0d", tag, i), 32'(exp4[i].size()), 0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_left3_out%0d", tag, i), 32'(exp3[i].size()), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; i_d4 = '0; or4 = '0;
        v3 = 1'b0; i_d3 = '0; or3 = '0;
        do_reset();

        // Reset state
        chk("rst_out_valid4", 32'(ov4), 0);
        chk("rst_in_ready4", 32'(r4), 1);
        chk("rst_out_valid3", 32'(ov3), 0);
        chk("rst_in_ready3", 32'(r3), 1);

        // N=4 all ready, 12 back-to-back items
        or4 = '1; stalls = 0; phase = 1;
        for (int k = 0; k < 12; k++) begin
            exp4[k % 4].push_back(16'(16'h0010 + k));
            send(0, 16'(16'h0010 + k));
        end
        repeat (4) tick();
        phase = 0;
        chk("t1_stalls", 32'(stalls), 0);
        chk("t1_pop_span", 32'(last_pop - first_pop), 11);
        chk_drained("t1");

        // N=4 with output 1 stalled
        do_reset();
        or4 = 4'b1101; stalls = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    exp4[t2_map[k]].push_back(16'(16'h0100 + k));
                    send(0, 16'(16'h0100 + k));
                end
            end
            begin
                repeat (5) tick();
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    chk("t2_hold_valid1", 32'(ov4[1]), 1);
                    chk("t2_hold_data1", 32'(od4[1]), 32'h0101);
                end
                @(posedge clk);
                #1;
                or4 = '1;
            end
        join
        repeat (6) tick();
`ifdef META_INTF_RR_DISPATCH_STRICT_EN
        chk("t2_input_stalled", 32'(stalls > 0), 1);
`else
        chk("t2_no_stall", 32'(stalls), 0);
`endif
        chk_drained("t2");

        // All outputs stalled with a full pipeline, then release output 2 once
        do_reset();
        or4 = '0;
        for (int k = 0; k < 4; k++) exp4[k].push_back(16'(16'h0300 + k));
        exp4[t3_last].push_back(16'h0304);
        for (int k = 0; k < 5; k++) send(0, 16'(16'h0300 + k));
        tick();
        chk("t3_full_ready", 32'(r4), 0);
        chk("t3_full_valid", 32'(ov4), 32'hF);
        or4 = 4'b0100;
        tick();
        or4 = '0;
        tick();
`ifdef META_INTF_RR_DISPATCH_STRICT_EN
        chk("t3_after_valid", 32'(ov4), 32'hB);
        chk("t3_after_ready", 32'(r4), 0);
`else
        chk("t3_after_valid", 32'(ov4), 32'hF);
        chk("t3_after_data2", 32'(od4[2]), 32'h0304);
        chk("t3_after_data0", 32'(od4[0]), 32'h0300);
        chk("t3_after_ready", 32'(r4), 1);
`endif
        or4 = '1;
        repeat (4) tick();
        chk_drained("t3");

        // Reset while three outputs hold items; those items must vanish
        do_reset();
        or4 = '0;
        for (int k = 0; k < 3; k++) send(0, 16'(16'h0400 + k));
        repeat (3) tick();
        chk("t4_pre_valid", 32'(ov4), 32'h7);
        do_reset();
        chk("t4_post_valid", 32'(ov4), 0);
        chk("t4_post_ready", 32'(r4), 1);
        or4 = '1;
        exp4[0].push_back(16'h04A0);
        send(0, 16'h04A0);
        repeat (4) tick();
        chk_drained("t4");

        // N=3, 9 items, all ready
        or3 = '1; stalls = 0;
        for (int k = 0; k < 9; k++) begin
            exp3[k % 3].push_back(16'(16'h0500 + k));
            send(1, 16'(16'h0500 + k));
        end
        repeat (4) tick();
        chk("t5_stalls", 32'(stalls), 0);
        chk_drained("t5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
